// File: rtl/dsc_result_accumulator.sv
// Sums ACC_LEN consecutive products from dsc_serial_mul into one saturating batch
// result, double-buffered behind a valid/ready output port.
//
//   state | meaning
//   ------+------------------------------------------------------------------
//   ACCUM | accepting products; output register free or holding one result
//   FULL  | output held and a finished batch waits in pacc; products dropped
module dsc_result_accumulator #(
   parameter int DATA_WIDTH = 5,
   parameter int NUM_INPUTS = 2,
   parameter int ACC_LEN    = 4,
   parameter int ACC_WIDTH  = 12
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               clr,
   input  logic [DATA_WIDTH*NUM_INPUTS-1:0]   prod_in,
   input  logic                               prod_valid,
   output logic                               mul_en,
   output logic [ACC_WIDTH-1:0]               acc_out,
   output logic                               acc_valid,
   input  logic                               acc_ready,
   output logic                               acc_ovf,
   output logic [7:0]                         drop_cnt
);

   localparam int PROD_WIDTH = DATA_WIDTH * NUM_INPUTS;
   localparam int CNT_W      = $clog2(ACC_LEN + 1);
   localparam int SUM_W      = ((ACC_WIDTH > PROD_WIDTH) ? ACC_WIDTH : PROD_WIDTH) + 1;
   localparam logic [ACC_WIDTH-1:0] ACC_MAX  = '1;
   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(ACC_LEN - 1);

   typedef enum logic {
      ACCUM = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t                 state;
   state_t                 state_nxt;

   logic [ACC_WIDTH-1:0]   wacc;
   logic [CNT_W-1:0]       wcnt;
   logic                   wovf;
   logic [ACC_WIDTH-1:0]   pacc;
   logic                   povf;

   logic [SUM_W-1:0]       sum;
   logic                   sum_sat;
   logic [ACC_WIDTH-1:0]   sum_clip;
   logic                   ovf_nxt;

   logic                   handshake;
   logic                   accept;
   logic                   complete;
   logic                   load_out_w;
   logic                   load_out_p;
   logic                   load_pend;
   logic                   clear_valid;
   logic                   drop;

   // Wide enough that neither operand can wrap before the saturation compare.
   assign sum      = SUM_W'(wacc) + SUM_W'(prod_in);
   assign sum_sat  = (sum > SUM_W'(ACC_MAX));
   assign sum_clip = sum_sat ? ACC_MAX : sum[ACC_WIDTH-1:0];
   assign ovf_nxt  = wovf | sum_sat;

   assign handshake = acc_valid & acc_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ACCUM;
      end else if (clr) begin
         state <= ACCUM;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      mul_en      = 1'b0;
      accept      = 1'b0;
      complete    = 1'b0;
      load_out_w  = 1'b0;
      load_out_p  = 1'b0;
      load_pend   = 1'b0;
      clear_valid = 1'b0;
      drop        = 1'b0;
      case (state)
         ACCUM: begin
            mul_en   = 1'b1;
            accept   = prod_valid;
            complete = prod_valid && (wcnt == CNT_LAST);
            if (complete) begin
               // A handshake this cycle frees the output register for the new sum.
               if (!acc_valid || handshake) begin
                  load_out_w = 1'b1;
               end else begin
                  load_pend = 1'b1;
                  state_nxt = FULL;
               end
            end else if (handshake) begin
               clear_valid = 1'b1;
            end
         end
         FULL: begin
            mul_en = 1'b0;
            drop   = prod_valid;
            if (handshake) begin
               load_out_p = 1'b1;
               state_nxt  = ACCUM;
            end
         end
         default: begin
            state_nxt = ACCUM;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wacc      <= '0;
         wcnt      <= '0;
         wovf      <= 1'b0;
         pacc      <= '0;
         povf      <= 1'b0;
         acc_out   <= '0;
         acc_ovf   <= 1'b0;
         acc_valid <= 1'b0;
         drop_cnt  <= '0;
      end else if (clr) begin
         wacc      <= '0;
         wcnt      <= '0;
         wovf      <= 1'b0;
         pacc      <= '0;
         povf      <= 1'b0;
         acc_out   <= '0;
         acc_ovf   <= 1'b0;
         acc_valid <= 1'b0;
         drop_cnt  <= '0;
      end else begin
         if (accept) begin
            if (complete) begin
               wacc <= '0;
               wcnt <= '0;
               wovf <= 1'b0;
            end else begin
               wacc <= sum_clip;
               wcnt <= wcnt + CNT_W'(1);
               wovf <= ovf_nxt;
            end
         end

         if (load_out_w) begin
            acc_out   <= sum_clip;
            acc_ovf   <= ovf_nxt;
            acc_valid <= 1'b1;
         end else if (load_out_p) begin
            acc_out   <= pacc;
            acc_ovf   <= povf;
            acc_valid <= 1'b1;
         end else if (clear_valid) begin
            acc_valid <= 1'b0;
         end

         if (load_pend) begin
            pacc <= sum_clip;
            povf <= ovf_nxt;
         end

         if (drop && (drop_cnt != 8'hff)) begin
            drop_cnt <= drop_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_dsc_result_accumulator.sv
// Scoreboard bench for dsc_result_accumulator: default instance plus a narrow
// ACC_WIDTH=10 / ACC_LEN=2 instance for saturation.
module tb_dsc_result_accumulator;

   logic        clk;
   logic        rst;

   logic        clr_a;
   logic [9:0]  prod_in_a;
   logic        prod_valid_a;
   logic        mul_en_a;
   logic [11:0] acc_out_a;
   logic        acc_valid_a;
   logic        acc_ready_a;
   logic        acc_ovf_a;
   logic [7:0]  drop_cnt_a;

   logic        clr_b;
   logic [9:0]  prod_in_b;
   logic        prod_valid_b;
   logic        mul_en_b;
   logic [9:0]  acc_out_b;
   logic        acc_valid_b;
   logic        acc_ready_b;
   logic        acc_ovf_b;
   logic [7:0]  drop_cnt_b;

   int total = 0;
   int bad   = 0;

   int exp_out_a[$];
   int exp_ovf_a[$];
   int exp_out_b[$];
   int exp_ovf_b[$];

   dsc_result_accumulator u_dut_a (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr_a),
      .prod_in    (prod_in_a),
      .prod_valid (prod_valid_a),
      .mul_en     (mul_en_a),
      .acc_out    (acc_out_a),
      .acc_valid  (acc_valid_a),
      .acc_ready  (acc_ready_a),
      .acc_ovf    (acc_ovf_a),
      .drop_cnt   (drop_cnt_a)
   );

   dsc_result_accumulator #(
      .DATA_WIDTH (5),
      .NUM_INPUTS (2),
      .ACC_LEN    (2),
      .ACC_WIDTH  (10)
   ) u_dut_b (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr_b),
      .prod_in    (prod_in_b),
      .prod_valid (prod_valid_b),
      .mul_en     (mul_en_b),
      .acc_out    (acc_out_b),
      .acc_valid  (acc_valid_b),
      .acc_ready  (acc_ready_b),
      .acc_ovf    (acc_ovf_b),
      .drop_cnt   (drop_cnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drv_a(input logic v, input int p, input logic r);
      @(posedge clk);
      #1;
      prod_valid_a = v;
      prod_in_a    = 10'(p);
      acc_ready_a  = r;
   endtask

   task automatic drv_b(input logic v, input int p, input logic r);
      @(posedge clk);
      #1;
      prod_valid_b = v;
      prod_in_b    = 10'(p);
      acc_ready_b  = r;
   endtask

   task automatic expect_a(input int o, input int f);
      exp_out_a.push_back(o);
      exp_ovf_a.push_back(f);
   endtask

   task automatic expect_b(input int o, input int f);
      exp_out_b.push_back(o);
      exp_ovf_b.push_back(f);
   endtask

   // Monitors: a result is consumed wherever valid and ready meet at the next edge.
   always @(negedge clk) begin
      if (!rst && !clr_a && acc_valid_a && acc_ready_a) begin
         if (exp_out_a.size() == 0) begin
            total++;
            bad++;
            $display("FAIL result_a: got out=%0d ovf=%0d expected no result", acc_out_a, acc_ovf_a);
         end else begin
            chk("result_a_out", int'(acc_out_a), exp_out_a.pop_front());
            chk("result_a_ovf", int'(acc_ovf_a), exp_ovf_a.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && !clr_b && acc_valid_b && acc_ready_b) begin
         if (exp_out_b.size() == 0) begin
            total++;
            bad++;
            $display("FAIL result_b: got out=%0d ovf=%0d expected no result", acc_out_b, acc_ovf_b);
         end else begin
            chk("result_b_out", int'(acc_out_b), exp_out_b.pop_front());
            chk("result_b_ovf", int'(acc_ovf_b), exp_ovf_b.pop_front());
         end
      end
   end

   initial begin
      rst          = 1'b1;
      clr_a        = 1'b0;
      prod_in_a    = '0;
      prod_valid_a = 1'b0;
      acc_ready_a  = 1'b0;
      clr_b        = 1'b0;
      prod_in_b    = '0;
      prod_valid_b = 1'b0;
      acc_ready_b  = 1'b0;

      #12;
      chk("rst_acc_out",   int'(acc_out_a),   0);
      chk("rst_acc_valid", int'(acc_valid_a), 0);
      chk("rst_acc_ovf",   int'(acc_ovf_a),   0);
      chk("rst_drop_cnt",  int'(drop_cnt_a),  0);
      chk("rst_mul_en",    int'(mul_en_a),    1);
      chk("rst_b_valid",   int'(acc_valid_b), 0);
      chk("rst_b_mul_en",  int'(mul_en_b),    1);
      rst = 1'b0;

      // Basic batch 3+7+10+20, consumer always ready.
      expect_a(40, 0);
      drv_a(1, 3, 1);
      drv_a(1, 7, 1);
      drv_a(1, 10, 1);
      drv_a(1, 20, 1);
      drv_a(0, 0, 1);
      chk("t1_latency_valid", int'(acc_valid_a), 1);
      chk("t1_acc_out",       int'(acc_out_a),   40);
      drv_a(0, 0, 1);
      chk("t1_valid_one_cycle", int'(acc_valid_a), 0);

      // Saturation on the narrow instance, then a clean batch.
      expect_b(1023, 1);
      expect_b(3, 0);
      drv_b(1, 600, 1);
      drv_b(1, 600, 1);
      drv_b(1, 1, 1);
      drv_b(1, 2, 1);
      drv_b(0, 0, 1);
      drv_b(0, 0, 0);
      chk("t2_b_valid_after", int'(acc_valid_b), 0);

      // Back-pressure: two batches of 1s with consumer stalled.
      expect_a(4, 0);
      expect_a(4, 0);
      for (int i = 0; i < 8; i++) drv_a(1, 1, 0);
      drv_a(0, 0, 0);
      chk("t3_mul_en_full", int'(mul_en_a),    0);
      chk("t3_valid_held",  int'(acc_valid_a), 1);
      chk("t3_out_held",    int'(acc_out_a),   4);
      for (int i = 0; i < 3; i++) drv_a(1, 9, 0);
      drv_a(0, 0, 0);
      chk("t3_drop_cnt",    int'(drop_cnt_a),  3);
      chk("t3_mul_en_still", int'(mul_en_a),   0);
      drv_a(0, 0, 1);
      drv_a(0, 0, 0);
      chk("t3_valid_after_hs", int'(acc_valid_a), 1);
      chk("t3_mul_en_after",   int'(mul_en_a),    1);
      chk("t3_second_out",     int'(acc_out_a),   4);
      drv_a(0, 0, 1);
      drv_a(0, 0, 0);
      chk("t3_drained", int'(acc_valid_a), 0);

      // Handshake coincident with batch completion: no FULL entry.
      expect_a(20, 0);
      expect_a(20, 0);
      for (int i = 0; i < 7; i++) drv_a(1, 5, 0);
      chk("t4_mul_en_pending", int'(mul_en_a), 1);
      drv_a(1, 5, 1);
      drv_a(0, 0, 0);
      chk("t4_valid_cont", int'(acc_valid_a), 1);
      chk("t4_mul_en",     int'(mul_en_a),    1);
      chk("t4_acc_out",    int'(acc_out_a),   20);
      drv_a(0, 0, 1);
      drv_a(0, 0, 0);
      chk("t4_drained", int'(acc_valid_a), 0);

      // Asynchronous reset mid-clock after a partial batch of 9,9.
      drv_a(1, 9, 1);
      drv_a(1, 9, 1);
      drv_a(0, 0, 1);
      #3;
      rst = 1'b1;
      #1;
      chk("t5_rst_out",   int'(acc_out_a),   0);
      chk("t5_rst_valid", int'(acc_valid_a), 0);
      chk("t5_rst_drop",  int'(drop_cnt_a),  0);
      chk("t5_rst_mul_en", int'(mul_en_a),   1);
      #2;
      rst = 1'b0;
      expect_a(4, 0);
      for (int i = 0; i < 4; i++) drv_a(1, 1, 1);
      drv_a(0, 0, 1);
      drv_a(0, 0, 0);

      // Synchronous clear coincident with a product of 50.
      for (int i = 0; i < 3; i++) drv_a(1, 7, 1);
      drv_a(1, 50, 1);
      clr_a = 1'b1;
      drv_a(0, 0, 1);
      clr_a = 1'b0;
      chk("t6_clr_valid",  int'(acc_valid_a), 0);
      chk("t6_clr_mul_en", int'(mul_en_a),    1);
      expect_a(8, 0);
      for (int i = 0; i < 4; i++) drv_a(1, 2, 1);
      drv_a(0, 0, 1);
      drv_a(0, 0, 0);
      chk("t6_drop_cnt", int'(drop_cnt_a), 0);

      drv_a(0, 0, 0);
      chk("queue_a_left", exp_out_a.size(), 0);
      chk("queue_b_left", exp_out_b.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
